// File: rtl/pre_if_stage.sv
// Pre-fetch control stage: owns the fetch PC, drives the instruction-side lookup,
// screens fetch exceptions, issues the I-cache request and hands the PC to IF.
//
// state | meaning
// LOOK  | req_pc presented to the translator (inst_fetch strobe)
// CHK   | translator result sampled; latch tag or fetch exception
// REQ   | I-cache request outstanding, waiting for icache_addr_ok
// OUT   | handoff to IF pending, waiting for fs_allowin
// HALT  | fetch exception delivered; idle until a redirect
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        csr_da,
    input  logic        csr_pg,
    input  logic [1:0]  csr_plv,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1,
    output logic [31:0] inst_vaddr,
    output logic        inst_fetch,
    output logic        inst_dmw0_en,
    output logic        inst_dmw1_en,
    output logic        inst_addr_trans_en,
    input  logic        inst_tlb_found,
    input  logic        inst_tlb_v,
    input  logic [1:0]  inst_tlb_plv,
    input  logic [19:0] inst_tag,
    output logic        icache_valid,
    output logic [19:0] icache_tag,
    input  logic        icache_addr_ok,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    input  logic        fs_allowin,
    output logic        fs_exc,
    output logic [5:0]  fs_ecode,
    output logic [8:0]  fs_esubcode,
    output logic        drop_resp
);

    typedef enum logic [2:0] {
        LOOK = 3'd0,
        CHK  = 3'd1,
        REQ  = 3'd2,
        OUT  = 3'd3,
        HALT = 3'd4
    } state_t;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PPI  = 6'h07;

    state_t      state, state_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic        exc, exc_nxt;
    logic [5:0]  ecode, ecode_nxt;
    logic [8:0]  esubcode, esubcode_nxt;
    logic [19:0] tag_q, tag_nxt;

    logic        pg_mode;
    logic        dmw0_hit;
    logic        dmw1_hit;
    logic        trans_en;
    logic        chk_exc;
    logic [5:0]  chk_ecode;

    // DMW bits other than PLV0/PLV3/VSEG carry nothing for instruction fetch.
    logic        unused_dmw_bits;
    assign unused_dmw_bits = ^{csr_dmw0[28:4], csr_dmw0[2:1], csr_dmw1[28:4], csr_dmw1[2:1]};

    assign pg_mode  = !csr_da && csr_pg;
    assign dmw0_hit = pg_mode
                      && ((csr_plv == 2'd0 && csr_dmw0[0]) || (csr_plv == 2'd3 && csr_dmw0[3]))
                      && (csr_dmw0[31:29] == req_pc[31:29]);
    assign dmw1_hit = pg_mode
                      && ((csr_plv == 2'd0 && csr_dmw1[0]) || (csr_plv == 2'd3 && csr_dmw1[3]))
                      && (csr_dmw1[31:29] == req_pc[31:29]);
    assign trans_en = pg_mode && !dmw0_hit && !dmw1_hit;

    // Fetch exception screen, first match wins.
    always_comb begin
        chk_exc   = 1'b1;
        chk_ecode = ECODE_ADEF;
        if ((req_pc[1:0] != 2'b00) || (pg_mode && trans_en && csr_plv == 2'd3 && req_pc[31])) begin
            chk_ecode = ECODE_ADEF;
        end else if (trans_en && !inst_tlb_found) begin
            chk_ecode = ECODE_TLBR;
        end else if (trans_en && !inst_tlb_v) begin
            chk_ecode = ECODE_PIF;
        end else if (trans_en && (csr_plv > inst_tlb_plv)) begin
            chk_ecode = ECODE_PPI;
        end else begin
            chk_exc = 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_pc_nxt   = req_pc;
        exc_nxt      = exc;
        ecode_nxt    = ecode;
        esubcode_nxt = esubcode;
        tag_nxt      = tag_q;
        if (redirect_valid) begin
            state_nxt  = LOOK;
            req_pc_nxt = redirect_pc;
            exc_nxt    = 1'b0;
        end else begin
            case (state)
                LOOK: state_nxt = CHK;
                CHK: begin
                    if (chk_exc) begin
                        exc_nxt      = 1'b1;
                        ecode_nxt    = chk_ecode;
                        esubcode_nxt = 9'd0;
                        state_nxt    = OUT;
                    end else begin
                        tag_nxt   = inst_tag;
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (icache_addr_ok) state_nxt = OUT;
                end
                OUT: begin
                    if (fs_allowin) begin
                        if (exc) begin
                            state_nxt = HALT;
                        end else begin
                            req_pc_nxt = req_pc + 32'd4;
                            state_nxt  = LOOK;
                        end
                    end
                end
                HALT: state_nxt = HALT;
                default: state_nxt = LOOK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOOK;
            req_pc   <= RESET_PC;
            exc      <= 1'b0;
            ecode    <= 6'd0;
            esubcode <= 9'd0;
            tag_q    <= 20'd0;
        end else begin
            state    <= state_nxt;
            req_pc   <= req_pc_nxt;
            exc      <= exc_nxt;
            ecode    <= ecode_nxt;
            esubcode <= esubcode_nxt;
            tag_q    <= tag_nxt;
        end
    end

    assign inst_vaddr         = req_pc;
    assign inst_fetch         = (state == LOOK);
    assign inst_dmw0_en       = dmw0_hit;
    assign inst_dmw1_en       = dmw1_hit;
    assign inst_addr_trans_en = trans_en;

    assign icache_valid = (state == REQ);
    assign icache_tag   = tag_q;

    // A redirect always wins over a handoff in the same cycle.
    assign fs_valid    = (state == OUT) && !redirect_valid;
    assign fs_pc       = req_pc;
    assign fs_exc      = exc;
    assign fs_ecode    = ecode;
    assign fs_esubcode = esubcode;

    assign drop_resp = redirect_valid
                       && (((state == REQ) && icache_addr_ok) || ((state == OUT) && !exc));

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: expected handoffs are queued as each
// fetch is launched and compared when IF accepts them.
module tb_pre_if_stage;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_da, csr_pg;
    logic [1:0]  csr_plv;
    logic [31:0] csr_dmw0, csr_dmw1;
    logic [31:0] inst_vaddr;
    logic        inst_fetch, inst_dmw0_en, inst_dmw1_en, inst_addr_trans_en;
    logic        inst_tlb_found, inst_tlb_v;
    logic [1:0]  inst_tlb_plv;
    logic [19:0] inst_tag;
    logic        icache_valid;
    logic [19:0] icache_tag;
    logic        icache_addr_ok;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_allowin;
    logic        fs_exc;
    logic [5:0]  fs_ecode;
    logic [8:0]  fs_esubcode;
    logic        drop_resp;

    pre_if_stage #(.RESET_PC(32'h1C000000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv),
        .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .inst_vaddr(inst_vaddr), .inst_fetch(inst_fetch),
        .inst_dmw0_en(inst_dmw0_en), .inst_dmw1_en(inst_dmw1_en),
        .inst_addr_trans_en(inst_addr_trans_en),
        .inst_tlb_found(inst_tlb_found), .inst_tlb_v(inst_tlb_v),
        .inst_tlb_plv(inst_tlb_plv), .inst_tag(inst_tag),
        .icache_valid(icache_valid), .icache_tag(icache_tag),
        .icache_addr_ok(icache_addr_ok),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_allowin(fs_allowin),
        .fs_exc(fs_exc), .fs_ecode(fs_ecode), .fs_esubcode(fs_esubcode),
        .drop_resp(drop_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        logic [5:0]  ecode;
    } sb_t;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  plv;
        logic [31:0] dmw0;
        logic [31:0] dmw1;
        logic        found;
        logic        v;
        logic [1:0]  tplv;
        logic        d0;
        logic        d1;
        logic        te;
        logic        exc;
        logic [5:0]  ecode;
    } row_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    row_t rows[9];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    // Called in the LOOK cycle of a fetch; returns in the cycle fs_valid is seen.
    task automatic wait_handoff(input string nm, input int exp_lat, input logic exp_exc,
                                input logic [19:0] exp_tag);
        int   n;
        logic saw;
        n   = 1;
        saw = 1'b0;
        while (!fs_valid && n < 20) begin
            if (icache_valid) begin
                saw = 1'b1;
                chk({nm, "_tag"}, {12'd0, icache_tag}, {12'd0, exp_tag});
            end
            tick();
            n++;
        end
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_icv"}, {31'd0, saw}, {31'd0, !exp_exc});
    endtask

    function automatic row_t mk(input logic [31:0] pc, input logic [1:0] plv,
                                input logic [31:0] dmw0, input logic [31:0] dmw1,
                                input logic found, input logic v, input logic [1:0] tplv,
                                input logic d0, input logic d1, input logic te,
                                input logic exc, input logic [5:0] ecode);
        row_t r;
        r.pc = pc; r.plv = plv; r.dmw0 = dmw0; r.dmw1 = dmw1;
        r.found = found; r.v = v; r.tplv = tplv;
        r.d0 = d0; r.d1 = d1; r.te = te; r.exc = exc; r.ecode = ecode;
        return r;
    endfunction

    task automatic run_row(input row_t r, input int idx);
        logic [19:0] tag;
        tag            = 20'h12340 + idx[19:0];
        csr_da         = 1'b0;
        csr_pg         = 1'b1;
        csr_plv        = r.plv;
        csr_dmw0       = r.dmw0;
        csr_dmw1       = r.dmw1;
        inst_tlb_found = r.found;
        inst_tlb_v     = r.v;
        inst_tlb_plv   = r.tplv;
        inst_tag       = tag;
        sb_q.push_back('{r.pc, r.exc, r.ecode});
        redirect_to(r.pc);
        chk($sformatf("row%0d_vaddr", idx), inst_vaddr, r.pc);
        chk($sformatf("row%0d_fetch", idx), {31'd0, inst_fetch}, 32'd1);
        chk($sformatf("row%0d_dmw0", idx), {31'd0, inst_dmw0_en}, {31'd0, r.d0});
        chk($sformatf("row%0d_dmw1", idx), {31'd0, inst_dmw1_en}, {31'd0, r.d1});
        chk($sformatf("row%0d_te", idx), {31'd0, inst_addr_trans_en}, {31'd0, r.te});
        chk($sformatf("row%0d_exc_clr", idx), {31'd0, fs_exc}, 32'd0);
        wait_handoff($sformatf("row%0d", idx), r.exc ? 3 : 4, r.exc, tag);
        tick();
        if (r.exc) begin
            repeat (2) begin
                chk($sformatf("row%0d_halt_fetch", idx), {31'd0, inst_fetch}, 32'd0);
                chk($sformatf("row%0d_halt_fsv", idx), {31'd0, fs_valid}, 32'd0);
                tick();
            end
        end
    endtask

    // Scoreboard side: every accepted handoff must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && fs_valid && fs_allowin) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_handoff", {31'd0, fs_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_pc", fs_pc, mon_e.pc);
                chk("sb_exc", {31'd0, fs_exc}, {31'd0, mon_e.exc});
                if (mon_e.exc) begin
                    chk("sb_ecode", {26'd0, fs_ecode}, {26'd0, mon_e.ecode});
                    chk("sb_esubcode", {23'd0, fs_esubcode}, 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        csr_da         = 1'b1;
        csr_pg         = 1'b0;
        csr_plv        = 2'd0;
        csr_dmw0       = 32'd0;
        csr_dmw1       = 32'd0;
        inst_tlb_found = 1'b0;
        inst_tlb_v     = 1'b0;
        inst_tlb_plv   = 2'd0;
        inst_tag       = 20'h1C000;
        icache_addr_ok = 1'b1;
        fs_allowin     = 1'b1;

        rows[0] = mk(32'h80001000, 2'd0, 32'h80000001, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        rows[1] = mk(32'h00400000, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3F);
        rows[2] = mk(32'h00400000, 2'd3, 32'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h07);
        rows[3] = mk(32'h00400000, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h03);
        rows[4] = mk(32'h00400002, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h08);
        rows[5] = mk(32'h80000000, 2'd3, 32'h0, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'h08);
        rows[6] = mk(32'hA0000000, 2'd3, 32'h0, 32'hA0000009, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
        rows[7] = mk(32'h00400000, 2'd3, 32'h0, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00);
        rows[8] = mk(32'h80001000, 2'd3, 32'h80000001, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'h08);

        repeat (2) tick();
        chk("rst_fetch", {31'd0, inst_fetch}, 32'd1);
        chk("rst_vaddr", inst_vaddr, 32'h1C000000);
        chk("rst_icv", {31'd0, icache_valid}, 32'd0);
        chk("rst_fsv", {31'd0, fs_valid}, 32'd0);
        chk("rst_exc", {31'd0, fs_exc}, 32'd0);
        chk("rst_tag", {12'd0, icache_tag}, 32'd0);
        chk("rst_drop", {31'd0, drop_resp}, 32'd0);

        // Direct mode, best-case back-to-back fetches.
        reset = 1'b0;
        #1;
        chk("t1_te", {31'd0, inst_addr_trans_en}, 32'd0);
        sb_q.push_back('{32'h1C000000, 1'b0, 6'h00});
        sb_q.push_back('{32'h1C000004, 1'b0, 6'h00});
        wait_handoff("t1a", 4, 1'b0, 20'h1C000);
        tick();
        wait_handoff("t1b", 4, 1'b0, 20'h1C000);
        tick();

        // Paged-mode table: DMW hits, TLB exceptions and their priority.
        for (int i = 0; i < 9; i++) run_row(rows[i], i);

        // Redirect out of HALT back to direct mode.
        csr_da   = 1'b1;
        csr_pg   = 1'b0;
        inst_tag = 20'h1C008;
        sb_q.push_back('{32'h1C008000, 1'b0, 6'h00});
        redirect_to(32'h1C008000);
        chk("halt_exit_vaddr", inst_vaddr, 32'h1C008000);
        chk("halt_exit_fetch", {31'd0, inst_fetch}, 32'd1);
        wait_handoff("halt_exit", 4, 1'b0, 20'h1C008);
        tick();

        // I-cache stall, then redirect the cycle addr_ok rises.
        icache_addr_ok = 1'b0;
        inst_tag       = 20'hBEEF1;
        redirect_to(32'h1C001000);
        repeat (2) tick();
        repeat (5) begin
            chk("stall_icv", {31'd0, icache_valid}, 32'd1);
            chk("stall_drop", {31'd0, drop_resp}, 32'd0);
            tick();
        end
        icache_addr_ok = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C002000;
        #1;
        chk("stall_rd_drop", {31'd0, drop_resp}, 32'd1);
        chk("stall_rd_fsv", {31'd0, fs_valid}, 32'd0);
        sb_q.push_back('{32'h1C002000, 1'b0, 6'h00});
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("stall_rd_drop_end", {31'd0, drop_resp}, 32'd0);
        chk("stall_rd_vaddr", inst_vaddr, 32'h1C002000);
        wait_handoff("stall_new", 4, 1'b0, 20'hBEEF1);
        tick();

        // IF back-pressure holds the handoff stable; a redirect in OUT drops it.
        fs_allowin = 1'b0;
        redirect_to(32'h1C004000);
        wait_handoff("hold", 4, 1'b0, 20'hBEEF1);
        repeat (3) begin
            chk("hold_fsv", {31'd0, fs_valid}, 32'd1);
            chk("hold_pc", fs_pc, 32'h1C004000);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C005000;
        #1;
        chk("out_rd_drop", {31'd0, drop_resp}, 32'd1);
        chk("out_rd_fsv", {31'd0, fs_valid}, 32'd0);
        fs_allowin = 1'b1;
        sb_q.push_back('{32'h1C005000, 1'b0, 6'h00});
        tick();
        redirect_valid = 1'b0;
        #1;
        wait_handoff("out_rd_new", 4, 1'b0, 20'hBEEF1);
        tick();

        // PC wraps through zero without an exception.
        sb_q.push_back('{32'hFFFFFFFC, 1'b0, 6'h00});
        sb_q.push_back('{32'h00000000, 1'b0, 6'h00});
        redirect_to(32'hFFFFFFFC);
        wait_handoff("wrap_a", 4, 1'b0, 20'hBEEF1);
        tick();
        chk("wrap_vaddr", inst_vaddr, 32'h00000000);
        wait_handoff("wrap_b", 4, 1'b0, 20'hBEEF1);
        tick();

        // Asynchronous reset in the middle of a stalled request.
        icache_addr_ok = 1'b0;
        redirect_to(32'h1C003000);
        repeat (2) tick();
        chk("mreq_icv", {31'd0, icache_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mreq_rst_icv", {31'd0, icache_valid}, 32'd0);
        chk("mreq_rst_vaddr", inst_vaddr, 32'h1C000000);
        tick();
        reset          = 1'b0;
        icache_addr_ok = 1'b1;
        inst_tag       = 20'h1C000;
        #1;
        chk("mreq_look_fetch", {31'd0, inst_fetch}, 32'd1);
        sb_q.push_back('{32'h1C000000, 1'b0, 6'h00});
        wait_handoff("mreq_after", 4, 1'b0, 20'h1C000);
        tick();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
